tcp_vlg_ka_tx: RTL

Keep-alive probe generator sitting directly downstream of the TCP keep-alive timer. It consumes the timer's level `send` request. It snapshots the connection's sequence state and builds a zero- or one-byte keep-alive segment descriptor (SEQ = SND.NXT−1, ACK flag only). It offers that descriptor to the TCP TX arbiter over a valid/ready handshake and pulses `sent` back to the timer once the arbiter accepts it.

---
 rtl/tcp_vlg_ka_tx_if.sv | 29 ++
 rtl/tcp_vlg_ka_tx.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_ka_tx_if.sv
// Keep-alive descriptor handshake between the probe generator (master)
// and the TCP TX arbiter (slave).
//   ka_val / ka_rdy : valid/ready handshake
//   ka_src_port, ka_dst_port, ka_seq, ka_ack, ka_flags, ka_wnd,
//   ka_ipv4_dst, ka_len : descriptor fields, stable while ka_val is high
interface tcp_vlg_ka_tx_if;
    logic        ka_val;
    logic        ka_rdy;
    logic [15:0] ka_src_port;
    logic [15:0] ka_dst_port;
    logic [31:0] ka_seq;
    logic [31:0] ka_ack;
    logic [8:0]  ka_flags;
    logic [15:0] ka_wnd;
    logic [31:0] ka_ipv4_dst;
    logic        ka_len;

    modport master (
        output ka_val, ka_src_port, ka_dst_port, ka_seq, ka_ack,
               ka_flags, ka_wnd, ka_ipv4_dst, ka_len,
        input  ka_rdy
    );

    modport slave (
        input  ka_val, ka_src_port, ka_dst_port, ka_seq, ka_ack,
               ka_flags, ka_wnd, ka_ipv4_dst, ka_len,
        output ka_rdy
    );
endinterface

// File: rtl/tcp_vlg_ka_tx.sv
// TCP keep-alive probe generator. On a timer request it snapshots the
// connection state, offers a SEQ = SND.NXT-1 ACK-only descriptor to the
// TX arbiter and reports acceptance (o_sent) or grant timeout (o_fail).
//   clk, rst      : clock, synchronous active-high reset
//   i_connected   : TCP connection established (level)
//   i_send        : keep-alive request from the timer (level)
//   o_sent/o_fail : one-cycle completion / abandon pulses
//   i_loc_*, i_rem_* : TCB fields snapshotted into the descriptor
//   o_ka_cnt      : saturating count of accepted probes
//   ka            : descriptor handshake to the TX arbiter
module tcp_vlg_ka_tx #(
    parameter int unsigned GARBAGE_BYTE  = 0,
    parameter int unsigned GRANT_TIMEOUT = 1250,
    parameter int unsigned HOLDOFF       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_connected,
    input  logic                  i_send,
    output logic                  o_sent,
    output logic                  o_fail,
    input  logic [31:0]           i_loc_seq,
    input  logic [31:0]           i_loc_ack,
    input  logic [15:0]           i_loc_port,
    input  logic [15:0]           i_rem_port,
    input  logic [31:0]           i_rem_ipv4,
    input  logic [15:0]           i_loc_wnd,
    output logic [15:0]           o_ka_cnt,
    tcp_vlg_ka_tx_if.master       ka
);

    localparam int unsigned GW        = $clog2(GRANT_TIMEOUT);
    localparam int unsigned HW        = $clog2(HOLDOFF);
    localparam logic [8:0]  FLAGS_ACK = 9'h010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE,
        S_HOLDOFF
    } state_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [8:0]  flags;
        logic [15:0] wnd;
        logic [31:0] ipv4_dst;
        logic        len;
    } desc_t;

    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_gcnt,  w_gcnt_nxt;
    logic [HW-1:0] r_hcnt,  w_hcnt_nxt;
    logic          r_val,   w_val_nxt;
    logic          r_sent,  w_sent_nxt;
    logic          r_fail,  w_fail_nxt;
    logic [15:0]   r_cnt,   w_cnt_nxt;
    desc_t         r_desc,  w_desc_nxt;

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_gcnt_nxt  = r_gcnt;
        w_hcnt_nxt  = r_hcnt;
        w_val_nxt   = r_val;
        w_sent_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_desc_nxt  = r_desc;

        case (r_state)
            S_IDLE: begin
                if (i_connected && i_send) begin
                    w_desc_nxt.src_port = i_loc_port;
                    w_desc_nxt.dst_port = i_rem_port;
                    w_desc_nxt.seq      = i_loc_seq - 32'd1;
                    w_desc_nxt.ack      = i_loc_ack;
                    w_desc_nxt.flags    = FLAGS_ACK;
                    w_desc_nxt.wnd      = i_loc_wnd;
                    w_desc_nxt.ipv4_dst = i_rem_ipv4;
                    w_desc_nxt.len      = (GARBAGE_BYTE != 0);
                    w_val_nxt           = 1'b1;
                    w_gcnt_nxt          = '0;
                    w_state_nxt         = S_REQ;
                end
            end
            S_REQ: begin
                // A grant on the last allowed cycle still wins over the timeout
                if (r_val && ka.ka_rdy) begin
                    w_val_nxt   = 1'b0;
                    w_sent_nxt  = 1'b1;
                    w_cnt_nxt   = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
                    w_state_nxt = S_DONE;
                end else if (r_gcnt == GW'(GRANT_TIMEOUT - 1)) begin
                    w_val_nxt   = 1'b0;
                    w_fail_nxt  = 1'b1;
                    w_hcnt_nxt  = '0;
                    w_state_nxt = S_HOLDOFF;
                end else begin
                    w_gcnt_nxt = r_gcnt + GW'(1);
                end
            end
            S_DONE: begin
                w_hcnt_nxt  = '0;
                w_state_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                // send is ignored here: it may still be high from the timer's lag
                if (r_hcnt == HW'(HOLDOFF - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_val_nxt   = 1'b0;
            end
        endcase

        // Loss of connection overrides everything, including a coincident grant
        if (!i_connected) begin
            w_state_nxt = S_IDLE;
            w_val_nxt   = 1'b0;
            w_sent_nxt  = 1'b0;
            w_fail_nxt  = 1'b0;
            w_gcnt_nxt  = '0;
            w_hcnt_nxt  = '0;
            w_cnt_nxt   = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gcnt  <= '0;
            r_hcnt  <= '0;
            r_val   <= 1'b0;
            r_sent  <= 1'b0;
            r_fail  <= 1'b0;
            r_cnt   <= '0;
            r_desc  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gcnt  <= w_gcnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_val   <= w_val_nxt;
            r_sent  <= w_sent_nxt;
            r_fail  <= w_fail_nxt;
            r_cnt   <= w_cnt_nxt;
            r_desc  <= w_desc_nxt;
        end
    end

    assign o_sent         = r_sent;
    assign o_fail         = r_fail;
    assign o_ka_cnt       = r_cnt;
    assign ka.ka_val      = r_val;
    assign ka.ka_src_port = r_desc.src_port;
    assign ka.ka_dst_port = r_desc.dst_port;
    assign ka.ka_seq      = r_desc.seq;
    assign ka.ka_ack      = r_desc.ack;
    assign ka.ka_flags    = r_desc.flags;
    assign ka.ka_wnd      = r_desc.wnd;
    assign ka.ka_ipv4_dst = r_desc.ipv4_dst;
    assign ka.ka_len      = r_desc.len;

endmodule
